// File: rtl/clk_gate_pkg.sv
// Shared constants for the gated clock branch controller.
package clk_gate_pkg;

   localparam logic [1:0] ST_OFF  = 2'd0;
   localparam logic [1:0] ST_WAKE = 2'd1;
   localparam logic [1:0] ST_ON   = 2'd2;
   localparam logic [1:0] ST_IDLE = 2'd3;

   localparam int DEF_WAKE_CYC = 4;
   localparam int DEF_CW       = 8;

endpackage

// File: rtl/cyc_down_counter.sv
// Loadable down counter shared by the wake settle and idle timeout phases.
module cyc_down_counter #(
   parameter int CW = 8
) (
   input  logic          mclk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   input  logic          dec,
   output logic [CW-1:0] value
);

   // Load wins over decrement; the count holds at zero rather than wrapping.
   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         value <= '0;
      end else if (load) begin
         value <= load_val;
      end else if (dec && (value != '0)) begin
         value <= value - 1'b1;
      end
   end

endmodule

// File: rtl/clk_gate_ctrl.sv
// Clock gate sequencer: collects requests, opens the gate after a wake
// settle period, grants requesters, and closes after an idle timeout.
//
//  state | meaning
//  OFF   | gate closed, waiting for any request
//  WAKE  | gate open, clock settling, no grants yet
//  ON    | gate open, active requesters granted
//  IDLE  | gate open, no requests, idle timeout running
module clk_gate_ctrl
   import clk_gate_pkg::*;
#(
   parameter int NREQ     = 4,
   parameter int WAKE_CYC = DEF_WAKE_CYC,
   parameter int CW       = DEF_CW
) (
   input  logic            mclk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   input  logic            force_on,
   input  logic [CW-1:0]   cfg_idle,
   output logic            gate_en,
   output logic [NREQ-1:0] ack,
   output logic [1:0]      state
);

   localparam logic [CW-1:0] WAKE_LOAD = CW'(WAKE_CYC - 1);

   logic          any_req;
   logic [1:0]    state_next;
   logic          cnt_load;
   logic [CW-1:0] cnt_load_val;
   logic          cnt_dec;
   logic [CW-1:0] cnt;

   assign any_req = (|req) | force_on;

   cyc_down_counter #(.CW(CW)) u_cnt (
      .mclk     (mclk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .dec      (cnt_dec),
      .value    (cnt)
   );

   // Next-state and counter control. cfg_idle is only looked at on the
   // transition into IDLE, so later changes wait for the next idle entry.
   // A zero idle timeout closes the gate directly instead of parking in IDLE.
   always_comb begin
      state_next   = state;
      cnt_load     = 1'b0;
      cnt_load_val = '0;
      cnt_dec      = 1'b0;
      case (state)
         ST_OFF: begin
            if (any_req) begin
               state_next   = ST_WAKE;
               cnt_load     = 1'b1;
               cnt_load_val = WAKE_LOAD;
            end
         end
         ST_WAKE: begin
            if (cnt == '0) begin
               if (any_req) begin
                  state_next = ST_ON;
               end else if (cfg_idle == '0) begin
                  state_next = ST_OFF;
               end else begin
                  state_next   = ST_IDLE;
                  cnt_load     = 1'b1;
                  cnt_load_val = cfg_idle;
               end
            end else begin
               cnt_dec = 1'b1;
            end
         end
         ST_ON: begin
            if (!any_req) begin
               if (cfg_idle == '0) begin
                  state_next = ST_OFF;
               end else begin
                  state_next   = ST_IDLE;
                  cnt_load     = 1'b1;
                  cnt_load_val = cfg_idle;
               end
            end
         end
         ST_IDLE: begin
            // Clock is still running, so a new request skips the wake delay
            // and beats a simultaneous timeout expiry.
            if (any_req) begin
               state_next = ST_ON;
            end else if (cnt <= CW'(1)) begin
               state_next = ST_OFF;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         default: state_next = ST_OFF;
      endcase
   end

   // State and outputs registered from next state; no req-to-output comb path.
   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_OFF;
         gate_en <= 1'b0;
         ack     <= '0;
      end else begin
         state   <= state_next;
         gate_en <= (state_next != ST_OFF);
         ack     <= (state_next == ST_ON) ? req : '0;
      end
   end

endmodule
